seven_seg_decoder: RTL
======================

SEVEN_SEG_DECODER -- requirements
Module: seven_seg_decoder

Interface
REQ-001 The block SHALL have parameter SEG_ACTIVE_LOW, default 0; when 1, seg_in is inverted before decode.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port seg_in, input, 7, segment pattern, bit6=a ... bit0=g, active-high.
REQ-005 The block SHALL have port pos_in, input, 8, digit select, one-hot, bit k = digit k.
REQ-006 The block SHALL have port frame, output, 32, decoded digits, nibble k = digit k.
REQ-007 The block SHALL have port blank_mask, output, 8, bit k set when digit k was all-segments-off.
REQ-008 The block SHALL have port err_mask, output, 8, bit k set when digit k had an undecodable pattern.
REQ-009 The block SHALL have port frame_valid, output, 1, one-cycle pulse when frame, blank_mask and err_mask update.
REQ-010 The block SHALL have port seq_err, output, 1, one-cycle pulse on an out-of-order or multi-hot pos_in.
REQ-011 The block SHALL have port frame_cnt, output, 8, count of completed frames.

Function
REQ-012 seg_in and pos_in SHALL be registered once; all decisions use the registered copies.
REQ-013 Decode SHALL be: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9, 1110111=A, 0011111=b, 1001110=C, 0111101=d, 1001111=E, 1000111=F.
REQ-014 Pattern 0000000 SHALL give nibble 0, blank bit 1, err bit 0; any other unlisted pattern SHALL give nibble 0, blank bit 0, err bit 1.
REQ-015 FSM SHALL have states IDLE (awaiting digit 0) and SCAN (awaiting digit exp_idx, 3 bits).
REQ-016 Registered pos_in == 0 SHALL be ignored: no state change, no error.
REQ-017 A multi-hot registered pos_in SHALL pulse seq_err, discard the partial frame, and go to IDLE.
REQ-018 One-hot index equal to the last accepted index (hold) SHALL overwrite that digit's shadow entry, with no advance and no error; this includes a hold on digit 7 after frame completion.
REQ-019 In IDLE, index 0 SHALL be captured to shadow, with exp_idx=1 and state SCAN; any other new index SHALL be ignored without error.
REQ-020 In SCAN, index == exp_idx SHALL be captured and exp_idx incremented.
REQ-021 In SCAN, any other non-hold index SHALL pulse seq_err and discard the partial frame; if that index is 0, it SHALL be captured as a new frame start (SCAN, exp_idx=1), otherwise the state SHALL go to IDLE.
REQ-022 Capture of index 7 SHALL copy shadow (with digit 7) to frame/blank_mask/err_mask, pulse frame_valid, increment frame_cnt (255 wraps to 0), and go to IDLE.
REQ-023 Latency: pos_in=bit7 sampled at edge E SHALL produce updated outputs and frame_valid high after edge E+1.
REQ-024 frame, blank_mask and err_mask SHALL hold their values between completed frames; partial frames SHALL never reach the outputs.

Reset
REQ-025 rst SHALL immediately force: frame=0, blank_mask=0, err_mask=0, frame_valid=0, seq_err=0, frame_cnt=0, state IDLE, shadow and input registers 0, last-accepted index invalid.
REQ-026 Reset mid-frame SHALL discard the partial frame; after release, capture SHALL begin only at digit 0.

Verification
REQ-027 Scan digits 0..7 with seg 0110000, 0000000 x6, 1111001 -> frame=0x30000001, blank_mask=0x7E, err_mask=0x00, one frame_valid, frame_cnt=1.
REQ-028 Each digit held 4 cycles, digit 2 changing 1101101->1111011 mid-hold -> nibble 2 = 9, no seq_err, one frame_valid.
REQ-029 Sequence 0,1,2,5 -> seq_err pulse at 5, no frame_valid; next 0..7 scan completes normally.
REQ-030 pos_in=8'b0000_0011 mid-frame -> seq_err pulse, state IDLE; seg 1010101 on digit 4 in a full scan -> err_mask=0x10.
REQ-031 256 complete scans -> frame_cnt wraps to 0; rst asserted at digit 3 -> all outputs 0 immediately, no frame_valid until a full 0..7 scan.
REQ-032 SEG_ACTIVE_LOW=1 with inverted patterns of REQ-027 -> identical frame, blank_mask and err_mask.

Source files
------------

// File: rtl/seven_seg_decoder_if.sv
// Bus bundle for the seven-segment scan decoder: the scanned segment/digit
// inputs and the frame-level results.
interface seven_seg_decoder_if;
    logic [6:0]  seg_in;
    logic [7:0]  pos_in;
    logic [31:0] frame;
    logic [7:0]  blank_mask;
    logic [7:0]  err_mask;
    logic        frame_valid;
    logic        seq_err;
    logic [7:0]  frame_cnt;

    // Side that drives the scanned display lines and observes decoded frames.
    modport master (
        output seg_in,
        output pos_in,
        input  frame,
        input  blank_mask,
        input  err_mask,
        input  frame_valid,
        input  seq_err,
        input  frame_cnt
    );

    // Decoder side.
    modport slave (
        input  seg_in,
        input  pos_in,
        output frame,
        output blank_mask,
        output err_mask,
        output frame_valid,
        output seq_err,
        output frame_cnt
    );
endinterface

// File: rtl/seven_seg_decoder.sv
// Seven-segment scan decoder: samples a multiplexed 8-digit display bus,
// decodes each digit's segment pattern to a hex nibble, and publishes a
// complete frame only once digits 0..7 have been seen in order.
module seven_seg_decoder #(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input logic               clk,
    input logic               rst,
    seven_seg_decoder_if.slave bus
);

    typedef enum logic {IDLE, SCAN} state_t;

    // Segment decode: returns {err, blank, nibble}. Bit 6 is segment a,
    // bit 0 is segment g.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            7'b1111110: res = {2'b00, 4'h0};
            7'b0110000: res = {2'b00, 4'h1};
            7'b1101101: res = {2'b00, 4'h2};
            7'b1111001: res = {2'b00, 4'h3};
            7'b0110011: res = {2'b00, 4'h4};
            7'b1011011: res = {2'b00, 4'h5};
            7'b1011111: res = {2'b00, 4'h6};
            7'b1110000: res = {2'b00, 4'h7};
            7'b1111111: res = {2'b00, 4'h8};
            7'b1111011: res = {2'b00, 4'h9};
            7'b1110111: res = {2'b00, 4'hA};
            7'b0011111: res = {2'b00, 4'hB};
            7'b1001110: res = {2'b00, 4'hC};
            7'b0111101: res = {2'b00, 4'hD};
            7'b1001111: res = {2'b00, 4'hE};
            7'b1000111: res = {2'b00, 4'hF};
            7'b0000000: res = {2'b01, 4'h0};
            default:    res = {2'b10, 4'h0};
        endcase
        return res;
    endfunction

    // Input sample stage
    logic [6:0]  r_seg_p0;
    logic [7:0]  r_pos_p0;

    // Frame tracking and output state
    state_t      r_state;
    logic [2:0]  r_exp_idx;
    logic [2:0]  r_last_idx;
    logic        r_last_vld;
    logic [31:0] r_sh_frame;
    logic [7:0]  r_sh_blank;
    logic [7:0]  r_sh_err;
    logic [31:0] r_frame;
    logic [7:0]  r_blank_mask;
    logic [7:0]  r_err_mask;
    logic        r_frame_valid;
    logic        r_seq_err;
    logic [7:0]  r_frame_cnt;

    logic [6:0]  w_seg;
    logic [5:0]  w_dec;
    logic [3:0]  w_nib;
    logic        w_blank;
    logic        w_err;
    logic        w_pos_zero;
    logic        w_multi;
    logic [2:0]  w_idx;
    logic        w_hold;
    logic [31:0] w_sh_frame;
    logic [7:0]  w_sh_blank;
    logic [7:0]  w_sh_err;

    // Register the raw display lines once; every decision below uses these.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_p0 <= 7'd0;
            r_pos_p0 <= 8'd0;
        end else begin
            r_seg_p0 <= bus.seg_in;
            r_pos_p0 <= bus.pos_in;
        end
    end

    // Decode stage: polarity fix-up happens before pattern lookup.
    assign w_seg      = SEG_ACTIVE_LOW ? ~r_seg_p0 : r_seg_p0;
    assign w_dec      = decode_seg(w_seg);
    assign w_nib      = w_dec[3:0];
    assign w_blank    = w_dec[4];
    assign w_err      = w_dec[5];
    assign w_pos_zero = (r_pos_p0 == 8'd0);
    assign w_multi    = ((r_pos_p0 & (r_pos_p0 - 8'd1)) != 8'd0);
    assign w_hold     = r_last_vld && (w_idx == r_last_idx);

    // Digit index of the (assumed one-hot) position select.
    always_comb begin
        w_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (r_pos_p0[k]) w_idx = 3'(k);
        end
    end

    // Shadow contents as they would look with the current digit written in;
    // used both for captures and for publishing the final digit of a frame.
    always_comb begin
        w_sh_frame = r_sh_frame;
        w_sh_blank = r_sh_blank;
        w_sh_err   = r_sh_err;
        w_sh_frame[{w_idx, 2'b00} +: 4] = w_nib;
        w_sh_blank[w_idx]               = w_blank;
        w_sh_err[w_idx]                 = w_err;
    end

    // Scan-order FSM with registered frame outputs and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_exp_idx     <= 3'd0;
            r_last_idx    <= 3'd0;
            r_last_vld    <= 1'b0;
            r_sh_frame    <= 32'd0;
            r_sh_blank    <= 8'd0;
            r_sh_err      <= 8'd0;
            r_frame       <= 32'd0;
            r_blank_mask  <= 8'd0;
            r_err_mask    <= 8'd0;
            r_frame_valid <= 1'b0;
            r_seq_err     <= 1'b0;
            r_frame_cnt   <= 8'd0;
        end else begin
            r_frame_valid <= 1'b0;
            r_seq_err     <= 1'b0;
            if (!w_pos_zero) begin
                if (w_multi) begin
                    // Ghosted select lines: the partial frame cannot be trusted.
                    r_seq_err  <= 1'b1;
                    r_state    <= IDLE;
                    r_last_vld <= 1'b0;
                end else if (w_hold) begin
                    // Same digit still being driven: latest pattern wins.
                    r_sh_frame <= w_sh_frame;
                    r_sh_blank <= w_sh_blank;
                    r_sh_err   <= w_sh_err;
                end else if (r_state == IDLE) begin
                    if (w_idx == 3'd0) begin
                        r_sh_frame <= w_sh_frame;
                        r_sh_blank <= w_sh_blank;
                        r_sh_err   <= w_sh_err;
                        r_exp_idx  <= 3'd1;
                        r_last_idx <= 3'd0;
                        r_last_vld <= 1'b1;
                        r_state    <= SCAN;
                    end
                end else if (w_idx == r_exp_idx) begin
                    r_sh_frame <= w_sh_frame;
                    r_sh_blank <= w_sh_blank;
                    r_sh_err   <= w_sh_err;
                    r_last_idx <= w_idx;
                    r_last_vld <= 1'b1;
                    if (w_idx == 3'd7) begin
                        r_frame       <= w_sh_frame;
                        r_blank_mask  <= w_sh_blank;
                        r_err_mask    <= w_sh_err;
                        r_frame_valid <= 1'b1;
                        r_frame_cnt   <= r_frame_cnt + 8'd1;
                        r_state       <= IDLE;
                    end else begin
                        r_exp_idx <= r_exp_idx + 3'd1;
                    end
                end else begin
                    // Skipped or repeated digit: drop the partial frame, but a
                    // jump back to digit 0 is treated as a fresh frame start.
                    r_seq_err <= 1'b1;
                    if (w_idx == 3'd0) begin
                        r_sh_frame <= w_sh_frame;
                        r_sh_blank <= w_sh_blank;
                        r_sh_err   <= w_sh_err;
                        r_exp_idx  <= 3'd1;
                        r_last_idx <= 3'd0;
                        r_last_vld <= 1'b1;
                        r_state    <= SCAN;
                    end else begin
                        r_state    <= IDLE;
                        r_last_vld <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.frame       = r_frame;
    assign bus.blank_mask  = r_blank_mask;
    assign bus.err_mask    = r_err_mask;
    assign bus.frame_valid = r_frame_valid;
    assign bus.seq_err     = r_seq_err;
    assign bus.frame_cnt   = r_frame_cnt;

endmodule
